// File: rtl/im_rx_packer.sv
// -----------------------------------------------------------------------------
// im_rx_packer
//
// Purpose:
//   Receives the imager ADC sample stream, which is asynchronous to sys_clk, and
//   answers the FSMIND0/FSMIND1 four-phase handshakes from the readout FSM.
//   im_data_clk, im_data_val and im_data are synchronised into sys_clk.
//   Captured 6-bit samples are packed five per 32-bit word, and each word
//   carries a frame-position tag. Words leave on a single-entry valid/ready
//   output register.
//
// Optional feature:
//   IM_RX_TESTPAT_EN - when defined, each captured sample is replaced by an
//   internal 6-bit counter. The counter clears on entry to CAPTURE and wraps
//   from 63 to 0. im_data is then ignored. Timing and handshakes do not change.
//
// Ports:
//   sys_clk      in   1   system clock, sole clock
//   RESET        in   1   synchronous active-high reset
//   im_data      in   6   ADC sample (async)
//   im_data_val  in   1   sample-valid qualifier (async)
//   im_data_clk  in   1   ADC strobe (async, slow)
//   FSMIND0      in   1   frame-start request
//   FSMIND0ACK   out  1   frame-start acknowledge
//   FSMIND1      in   1   readout-done request
//   FSMIND1ACK   out  1   readout-done acknowledge
//   word_data    out  32  [31:30] tag, [29:0] samples (sample 0 at [5:0])
//   word_valid   out  1   word available
//   word_ready   in   1   consumer accepts the word
//   frame_done   out  1   pulse after the frame's last word is accepted
//   overflow     out  1   sticky: a completed word was dropped
//   sample_cnt   out  16  samples captured in the current frame
//
// Tag encoding {last, first}: 01 first, 00 middle, 10 last, 11 single word.
// -----------------------------------------------------------------------------
module im_rx_packer #(
  parameter int SAMPLE_W         = 6,
  parameter int SAMPLES_PER_WORD = 5,
  parameter int FRAME_SAMPLES    = 1024,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                sys_clk,
  input  logic                RESET,
  input  logic [SAMPLE_W-1:0] im_data,
  input  logic                im_data_val,
  input  logic                im_data_clk,
  input  logic                FSMIND0,
  output logic                FSMIND0ACK,
  input  logic                FSMIND1,
  output logic                FSMIND1ACK,
  output logic [31:0]         word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                frame_done,
  output logic                overflow,
  output logic [15:0]         sample_cnt
);

  localparam int WORD_BITS = SAMPLE_W * SAMPLES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] val_sync_q;
  logic [SAMPLE_W-1:0]    data_sync_q [SYNC_STAGES];
  logic                   clk_prev_q;
  logic [1:0]             ind0_sync_q;
  logic [1:0]             ind1_sync_q;
  logic [15:0]            cnt_q;
  logic [2:0]             slot_q;
  logic [WORD_BITS-1:0]   pack_q;
  logic                   first_q;
  logic [31:0]            word_q;
  logic                   word_valid_q;
  logic                   ack0_q;
  logic                   ack1_q;
  logic                   frame_done_q;
  logic                   overflow_q;

  logic                   ind0_s;
  logic                   ind1_s;
  logic                   clk_rise_s;
  logic                   capture_s;
  logic                   last_sample_s;
  logic                   accept_s;
  logic [SAMPLE_W-1:0]    sample_s;
  logic [4:0]             shamt_s;
  logic [WORD_BITS-1:0]   merged_s;
  logic                   emit_s;
  logic [31:0]            emit_word_s;

  // Synchroniser chains for the ADC strobe, qualifier, data and the handshake requests.
  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      clk_sync_q  <= '0;
      val_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      ind0_sync_q <= 2'b00;
      ind1_sync_q <= 2'b00;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= '0;
      end
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], im_data_clk};
      val_sync_q  <= {val_sync_q[SYNC_STAGES-2:0], im_data_val};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      ind0_sync_q <= {ind0_sync_q[0], FSMIND0};
      ind1_sync_q <= {ind1_sync_q[0], FSMIND1};
      data_sync_q[0] <= im_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign ind0_s        = ind0_sync_q[1];
  assign ind1_s        = ind1_sync_q[1];
  assign clk_rise_s    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign capture_s     = (state_q == CAPTURE) & clk_rise_s & val_sync_q[SYNC_STAGES-1];
  assign last_sample_s = (cnt_q == 16'(FRAME_SAMPLES - 1));
  assign accept_s      = word_valid_q & word_ready;
  assign shamt_s       = 5'(slot_q) * 5'(SAMPLE_W);
  assign merged_s      = pack_q | (WORD_BITS'(sample_s) << shamt_s);

`ifdef IM_RX_TESTPAT_EN
  logic [SAMPLE_W-1:0] tp_q;

  // Test-pattern counter: cleared as CAPTURE is entered, advanced per capture event.
  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      tp_q <= '0;
    end else if ((state_q == ARM) && !ind0_s) begin
      tp_q <= '0;
    end else if (capture_s) begin
      tp_q <= tp_q + 1'b1;
    end
  end

  assign sample_s = tp_q;
`else
  assign sample_s = data_sync_q[SYNC_STAGES-1];
`endif

  // Word completion: slot 4 filled during CAPTURE, or a partial word left over in FLUSH.
  always_comb begin
    emit_s      = 1'b0;
    emit_word_s = 32'd0;
    if (capture_s && (slot_q == 3'(SAMPLES_PER_WORD - 1))) begin
      emit_s      = 1'b1;
      emit_word_s = {last_sample_s, first_q, merged_s};
    end else if ((state_q == FLUSH) && (slot_q != 3'd0)) begin
      emit_s      = 1'b1;
      emit_word_s = {1'b1, first_q, pack_q};
    end else begin
      emit_s      = 1'b0;
      emit_word_s = 32'd0;
    end
  end

  // Frame FSM, packer, output register and handshake acknowledges.
  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      slot_q       <= 3'd0;
      pack_q       <= '0;
      first_q      <= 1'b0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // A word completing in the same cycle the held word is accepted still loads.
      if (emit_s) begin
        if (!word_valid_q || accept_s) begin
          word_q       <= emit_word_s;
          word_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (accept_s) begin
        word_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (ind0_s) begin
            ack0_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          if (!ind0_s) begin
            ack0_q  <= 1'b0;
            cnt_q   <= 16'd0;
            slot_q  <= 3'd0;
            pack_q  <= '0;
            first_q <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (capture_s) begin
            cnt_q <= cnt_q + 16'd1;
            if (slot_q == 3'(SAMPLES_PER_WORD - 1)) begin
              slot_q  <= 3'd0;
              pack_q  <= '0;
              first_q <= 1'b0;
            end else begin
              slot_q <= slot_q + 3'd1;
              pack_q <= merged_s;
            end
            if (last_sample_s) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          slot_q  <= 3'd0;
          pack_q  <= '0;
          first_q <= 1'b0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          // An empty register here means the last word was either accepted or dropped.
          if ((accept_s && word_q[31]) || !word_valid_q) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (ind1_s && !ack1_q) begin
            ack1_q <= 1'b1;
          end else if (!ind1_s && ack1_q) begin
            ack1_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign FSMIND0ACK = ack0_q;
  assign FSMIND1ACK = ack1_q;
  assign word_data  = word_q;
  assign word_valid = word_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_im_rx_packer.sv
module tb_im_rx_packer;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  im_data = 6'd0;
  logic        im_val = 1'b0;
  logic        im_clk = 1'b0;

  logic        a_ind0 = 1'b0, a_ind1 = 1'b0, a_ready = 1'b0;
  logic        a_ack0, a_ack1, a_valid, a_fd, a_ovf;
  logic [31:0] a_word;
  logic [15:0] a_cnt;

  logic        b_ind0 = 1'b0, b_ind1 = 1'b0, b_ready = 1'b0;
  logic        b_ack0, b_ack1, b_valid, b_fd, b_ovf;
  logic [31:0] b_word;
  logic [15:0] b_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int fd_a = 0;
  int fd_b = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  always #5 sys_clk = ~sys_clk;

  im_rx_packer #(.FRAME_SAMPLES(12)) dut_a (
    .sys_clk(sys_clk), .RESET(rst), .im_data(im_data), .im_data_val(im_val),
    .im_data_clk(im_clk), .FSMIND0(a_ind0), .FSMIND0ACK(a_ack0),
    .FSMIND1(a_ind1), .FSMIND1ACK(a_ack1), .word_data(a_word),
    .word_valid(a_valid), .word_ready(a_ready), .frame_done(a_fd),
    .overflow(a_ovf), .sample_cnt(a_cnt)
  );

  im_rx_packer #(.FRAME_SAMPLES(3)) dut_b (
    .sys_clk(sys_clk), .RESET(rst), .im_data(im_data), .im_data_val(im_val),
    .im_data_clk(im_clk), .FSMIND0(b_ind0), .FSMIND0ACK(b_ack0),
    .FSMIND1(b_ind1), .FSMIND1ACK(b_ack1), .word_data(b_word),
    .word_valid(b_valid), .word_ready(b_ready), .frame_done(b_fd),
    .overflow(b_ovf), .sample_cnt(b_cnt)
  );

  // Reference packing: n consecutive sample values starting at base, plus tag.
  function automatic logic [31:0] mk_word(input logic [1:0] tag, input int base, input int n);
    logic [31:0] w;
    w = {tag, 30'd0};
    for (int i = 0; i < n; i++) begin
      w = w | (32'((base + i) & 63) << (6 * i));
    end
    return w;
  endfunction

  // Scoreboard: every accepted word is popped and compared; frame_done pulses counted.
  always @(negedge sys_clk) begin : monitor
    logic [31:0] e;
    if (a_fd) fd_a = fd_a + 1;
    if (b_fd) fd_b = fd_b + 1;
    if (!rst && a_valid && a_ready) begin
      n_checks = n_checks + 1;
      if (exp_a.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL word_a: unexpected word %h, required none", a_word);
      end else begin
        e = exp_a.pop_front();
        if (a_word !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL word_a: got %h, required %h", a_word, e);
        end
      end
    end
    if (!rst && b_valid && b_ready) begin
      n_checks = n_checks + 1;
      if (exp_b.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL word_b: unexpected word %h, required none", b_word);
      end else begin
        e = exp_b.pop_front();
        if (b_word !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL word_b: got %h, required %h", b_word, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_sample(input logic [5:0] v);
    im_data = v;
    im_val  = 1'b1;
    tick(2);
    im_clk = 1'b1;
    tick(5);
    im_clk = 1'b0;
    tick(4);
  endtask

  task automatic start_a();
    a_ind0 = 1'b1;
    for (int i = 0; i < 10 && a_ack0 !== 1'b1; i++) tick(1);
    n_checks++;
    if (a_ack0 !== 1'b1) begin n_fail++; $display("FAIL start_ack0_rise: got %b, required 1", a_ack0); end
    a_ind0 = 1'b0;
    for (int i = 0; i < 10 && a_ack0 !== 1'b0; i++) tick(1);
    n_checks++;
    if (a_ack0 !== 1'b0) begin n_fail++; $display("FAIL start_ack0_fall: got %b, required 0", a_ack0); end
  endtask

  task automatic finish_a();
    a_ind1 = 1'b1;
    for (int i = 0; i < 10 && a_ack1 !== 1'b1; i++) tick(1);
    n_checks++;
    if (a_ack1 !== 1'b1) begin n_fail++; $display("FAIL finish_ack1_rise: got %b, required 1", a_ack1); end
    a_ind1 = 1'b0;
    for (int i = 0; i < 10 && a_ack1 !== 1'b0; i++) tick(1);
    n_checks++;
    if (a_ack1 !== 1'b0) begin n_fail++; $display("FAIL finish_ack1_fall: got %b, required 0", a_ack1); end
  endtask

  task automatic wait_fd_a(input int target);
    for (int i = 0; i < 60 && fd_a < target; i++) tick(1);
    n_checks++;
    if (fd_a !== target) begin n_fail++; $display("FAIL frame_done_a: count %0d, required %0d", fd_a, target); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({a_valid, a_ack0, a_ack1, a_fd, a_ovf} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {a_valid, a_ack0, a_ack1, a_fd, a_ovf});
    end
    n_checks++;
    if (a_word !== 32'd0) begin n_fail++; $display("FAIL reset_word: got %h, required 0", a_word); end
    n_checks++;
    if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", a_cnt); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_word();
    b_ready = 1'b1;
    b_ind0  = 1'b1;
    for (int i = 0; i < 10 && b_ack0 !== 1'b1; i++) tick(1);
    b_ind0 = 1'b0;
    for (int i = 0; i < 10 && b_ack0 !== 1'b0; i++) tick(1);
    exp_b.push_back(mk_word(2'b11, 1, 3));
    send_sample(6'd1);
    send_sample(6'd2);
    send_sample(6'd3);
    for (int i = 0; i < 40 && fd_b < 1; i++) tick(1);
    n_checks++;
    if (fd_b !== 1) begin n_fail++; $display("FAIL single_frame_done: count %0d, required 1", fd_b); end
    n_checks++;
    if (b_cnt !== 16'd3) begin n_fail++; $display("FAIL single_cnt: got %0d, required 3", b_cnt); end
    n_checks++;
    if (exp_b.size() !== 0) begin n_fail++; $display("FAIL single_pending: got %0d words left, required 0", exp_b.size()); end
  endtask

  task automatic test_fsmind0();
    int cyc;
    a_ind0 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10 && a_ack0 !== 1'b1; i++) begin tick(1); cyc++; end
    n_checks++;
    if (a_ack0 !== 1'b1 || cyc > 4) begin
      n_fail++; $display("FAIL ack0_latency: ack %b after %0d cycles, required 1 within 4", a_ack0, cyc);
    end
    send_sample(6'd50);
    send_sample(6'd51);
    n_checks++;
    if (a_ack0 !== 1'b1) begin n_fail++; $display("FAIL ack0_hold: got %b, required 1", a_ack0); end
    a_ind0 = 1'b0;
    for (int i = 0; i < 10 && a_ack0 !== 1'b0; i++) tick(1);
    n_checks++;
    if (a_ack0 !== 1'b0) begin n_fail++; $display("FAIL ack0_drop: got %b, required 0", a_ack0); end
    n_checks++;
    if (a_cnt !== 16'd0 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL arm_edges_ignored: cnt %0d valid %b, required 0 0", a_cnt, a_valid);
    end
  endtask

  task automatic test_frame12();
    a_ready = 1'b1;
    exp_a.push_back(mk_word(2'b01, 0, 5));
    exp_a.push_back(mk_word(2'b00, 5, 5));
    exp_a.push_back(mk_word(2'b10, 10, 2));
    for (int v = 0; v < 12; v++) send_sample(6'(v));
    wait_fd_a(1);
    n_checks++;
    if (a_cnt !== 16'd12) begin n_fail++; $display("FAIL frame12_cnt: got %0d, required 12", a_cnt); end
    tick(5);
    n_checks++;
    if (fd_a !== 1) begin n_fail++; $display("FAIL frame12_single_pulse: count %0d, required 1", fd_a); end
    n_checks++;
    if (exp_a.size() !== 0) begin n_fail++; $display("FAIL frame12_pending: %0d words left, required 0", exp_a.size()); end
    finish_a();
  endtask

  task automatic test_overflow();
    start_a();
    a_ready = 1'b0;
    for (int v = 20; v < 30; v++) send_sample(6'(v));
    n_checks++;
    if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", a_ovf); end
    n_checks++;
    if (a_valid !== 1'b1 || a_word !== mk_word(2'b01, 20, 5)) begin
      n_fail++; $display("FAIL ovf_held: valid %b word %h, required 1 %h", a_valid, a_word, mk_word(2'b01, 20, 5));
    end
    exp_a.push_back(mk_word(2'b01, 20, 5));
    a_ready = 1'b1;
    tick(2);
    n_checks++;
    if (a_cnt !== 16'd10) begin n_fail++; $display("FAIL ovf_cnt: got %0d, required 10", a_cnt); end
    n_checks++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_second_lost: valid %b, required 0", a_valid); end
    exp_a.push_back(mk_word(2'b10, 30, 2));
    send_sample(6'd30);
    send_sample(6'd31);
    wait_fd_a(2);
    finish_a();
    n_checks++;
    if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", a_ovf); end
  endtask

  task automatic test_fsmind1_early();
    start_a();
    a_ready = 1'b1;
    exp_a.push_back(mk_word(2'b01, 60, 5));
    exp_a.push_back(mk_word(2'b00, 65, 5));
    exp_a.push_back(mk_word(2'b10, 70, 2));
    for (int v = 60; v < 65; v++) send_sample(6'(v));
    a_ind1 = 1'b1;
    for (int v = 65; v < 70; v++) send_sample(6'(v));
    n_checks++;
    if (a_ack1 !== 1'b0) begin n_fail++; $display("FAIL ack1_in_capture: got %b, required 0", a_ack1); end
    a_ready = 1'b0;
    send_sample(6'd70);
    send_sample(6'd71);
    tick(3);
    n_checks++;
    if (a_ack1 !== 1'b0 || a_valid !== 1'b1) begin
      n_fail++; $display("FAIL ack1_before_accept: ack %b valid %b, required 0 1", a_ack1, a_valid);
    end
    a_ready = 1'b1;
    for (int i = 0; i < 10 && a_ack1 !== 1'b1; i++) tick(1);
    n_checks++;
    if (a_ack1 !== 1'b1) begin n_fail++; $display("FAIL ack1_after_accept: got %b, required 1", a_ack1); end
    n_checks++;
    if (fd_a !== 3) begin n_fail++; $display("FAIL ack1_frame_done: count %0d, required 3", fd_a); end
    a_ind1 = 1'b0;
    for (int i = 0; i < 10 && a_ack1 !== 1'b0; i++) tick(1);
    n_checks++;
    if (a_ack1 !== 1'b0) begin n_fail++; $display("FAIL ack1_drop: got %b, required 0", a_ack1); end
  endtask

  task automatic test_reset_mid();
    start_a();
    a_ready = 1'b1;
    exp_a.push_back(mk_word(2'b01, 0, 5));
    for (int v = 0; v < 7; v++) send_sample(6'(v));
    n_checks++;
    if (a_cnt !== 16'd7) begin n_fail++; $display("FAIL mid_cnt_before: got %0d, required 7", a_cnt); end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (a_valid !== 1'b0 || a_cnt !== 16'd0 || a_ack0 !== 1'b0 || a_ovf !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: valid %b cnt %0d ack0 %b ovf %b, required 0 0 0 0", a_valid, a_cnt, a_ack0, a_ovf);
    end
    rst = 1'b0;
    tick(1);
    start_a();
    exp_a.push_back(mk_word(2'b01, 40, 5));
    exp_a.push_back(mk_word(2'b00, 45, 5));
    exp_a.push_back(mk_word(2'b10, 50, 2));
    for (int v = 40; v < 52; v++) send_sample(6'(v));
    wait_fd_a(4);
    finish_a();
    n_checks++;
    if (exp_a.size() !== 0) begin n_fail++; $display("FAIL mid_pending: %0d words left, required 0", exp_a.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fsmind0();
    test_frame12();
    test_overflow();
    test_fsmind1_early();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
